// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
//
// Purpose: groups the command port, the ALU-facing drive/return signals and
// the result port of alu_cmd_sequencer into one bundle.
//
// Handshake rule for both cmd_* and res_*: a transfer happens on a rising
// clock edge where valid and ready are both high. The producer holds valid
// and its payload stable until that edge. The consumer may raise or lower
// ready at any time.
//
// Signals:
//   cmd_valid/cmd_ready, cmd_a, cmd_b, cmd_op, cmd_chain  command port
//   alu_a, alu_b, alu_op                                  drive to the ALU
//   alu_result                                            return from the ALU
//   res_valid/res_ready, res_data                         result port
//   fifo_count                                            queued entries
//
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding environment (command source, ALU, result sink)
interface alu_cmd_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [1:0]       cmd_op;
    logic             cmd_chain;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [1:0]       alu_op;
    logic [31:0]      alu_result;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;

    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
        input  alu_result,
        input  res_ready,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        output res_valid, res_data,
        output fifo_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain,
        output alu_result,
        output res_ready,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        input  res_valid, res_data,
        input  fifo_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Purpose: command queue and result-capture stage around a 32-bit
// combinational ALU. Commands {a, b, op[, chain]} are accepted over a
// valid/ready handshake into a DEPTH-entry circular FIFO. The head entry is
// driven to the ALU combinationally and, when the result slot is free (or is
// being drained in the same cycle), the ALU result is registered into the
// result port and the head is popped.
//
// Optional feature (macro ALU_CHAIN_EN):
//   defined   - a head entry with chain=1 drives the previous result as
//               operand A instead of its stored a.
//   undefined - cmd_chain is ignored and not stored; no last-result register.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          alu_cmd_sequencer_if.slave (command, ALU and result signals)
//   dbg_state_o  result-slot state (0 = EMPTY, 1 = FULL)
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus,
    output logic                 dbg_state_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      res_data_q, res_data_d;

    logic [31:0]      mem_a  [DEPTH];
    logic [31:0]      mem_b  [DEPTH];
    logic [1:0]       mem_op [DEPTH];

    logic             fifo_empty;
    logic             cmd_ready;
    logic             push;
    logic             issue;

`ifdef ALU_CHAIN_EN
    logic             mem_chain [DEPTH];
    logic [31:0]      last_result_q, last_result_d;
`else
    logic             unused_chain;
    assign unused_chain = bus.cmd_chain;
`endif

    assign fifo_empty = (count_q == '0);
    // Registered count only: a pop in the same cycle never frees a slot for
    // a push, so cmd_ready has no path from res_ready.
    assign cmd_ready  = (count_q != FULL_CNT);
    assign push       = bus.cmd_valid && cmd_ready;
    // A new result may be captured when the slot is free or is being read
    // out at this very edge.
    assign issue      = !fifo_empty && ((state_q == S_EMPTY) || bus.res_ready);

    assign bus.cmd_ready  = cmd_ready;
    assign bus.res_valid  = (state_q == S_FULL);
    assign bus.res_data   = res_data_q;
    assign bus.fifo_count = count_q;
    assign dbg_state_o    = state_q;

    // Head entry drives the ALU; zeros when nothing is queued.
    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = '0;
        if (!fifo_empty) begin
            bus.alu_a  = mem_a[rd_ptr_q];
            bus.alu_b  = mem_b[rd_ptr_q];
            bus.alu_op = mem_op[rd_ptr_q];
`ifdef ALU_CHAIN_EN
            if (mem_chain[rd_ptr_q]) begin
                bus.alu_a = last_result_q;
            end
`endif
        end
    end

    // Next-state logic for the result slot, FIFO pointers and count.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        res_data_d = res_data_q;
`ifdef ALU_CHAIN_EN
        last_result_d = last_result_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (issue) begin
            rd_ptr_d   = rd_ptr_q + ONE_PTR;
            res_data_d = bus.alu_result;
`ifdef ALU_CHAIN_EN
            last_result_d = bus.alu_result;
`endif
        end

        case ({push, issue})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_EMPTY: begin
                if (issue) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                // Drained without a replacement: slot becomes free, data held.
                if (bus.res_ready && !issue) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            res_data_q <= '0;
`ifdef ALU_CHAIN_EN
            last_result_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            res_data_q <= res_data_d;
`ifdef ALU_CHAIN_EN
            last_result_q <= last_result_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q]  <= bus.cmd_a;
            mem_b[wr_ptr_q]  <= bus.cmd_b;
            mem_op[wr_ptr_q] <= bus.cmd_op;
`ifdef ALU_CHAIN_EN
            mem_chain[wr_ptr_q] <= bus.cmd_chain;
`endif
        end
    end
endmodule
